muldiv_hilo: RTL
================

// Module: muldiv_hilo
// PURPOSE
//  Iterative multiply/divide unit that owns the HI/LO register pair of the pipelined MIPS core.
//  Sits beside the EX-stage ALU: takes the ALU's a/b operands and drives the ALU's hi/lo inputs,
//  which mfhi/mflo read. Replaces the single-cycle a*b and a/b, a%b paths with a multi-cycle
//  datapath. Raises busy so the hazard unit can stall.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk    in   1      single clock, rising edge
//  reset  in   1      synchronous, active-high
//  start  in   1      request; sampled only while busy==0
//  op     in   3      muldiv_pkg::md_op_t: MULTU=0 DIVU=1 MULT=2 DIV=3 MTHI=4 MTLO=5
//  a      in   WIDTH  rs operand (dividend / multiplicand / move source)
//  b      in   WIDTH  rt operand (divisor / multiplier)
//  busy   out  1      operation in flight; hazard unit stalls mfhi/mflo/muldiv while high
//  done   out  1      one-cycle pulse in the cycle HI/LO first show a new mul/div result
//  hi     out  WIDTH  HI register (to ALU hi input)
//  lo     out  WIDTH  LO register (to ALU lo input)
// BEHAVIOUR
//  - Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts it.
//    HI/LO are not written with any partial result.
//  - FSM states: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  - IDLE, start=1, op MTHI/MTLO: at that edge hi<=a (or lo<=a). No busy, no done. Stays in IDLE.
//  - IDLE, start=1, op mul/div: latch operands, set sign flags, go to CALC, busy=1 from next cycle.
//  - CALC, one bit per cycle:
//    - mul: shift-add on the 2*WIDTH product.
//    - div: restoring step, remainder kept in WIDTH+1 bits.
//  - FIX: apply signs, then at the FIX edge write hi/lo, state<=IDLE, busy<=0, done<=1 (one cycle).
//  - Latency: start edge to HI/LO valid = WIDTH+1 edges (33 for WIDTH=32).
//  - Unknown op codes (6, 7) are ignored.
//  - start while busy=1 is ignored entirely; MTHI/MTLO are not queued either.
//  - Arithmetic rules:
//    - mul: {hi,lo} = full 2*WIDTH product.
//    - div: lo = quotient, hi = remainder. Signed divide truncates toward zero;
//      the remainder takes the dividend's sign.
//  - Divide by zero (b==0), any div op: lo = all-ones, hi = a. Completes with normal latency.
//  - Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo = 0x80000000, hi = 0.
//  - busy and done are never high in the same cycle.
// CONFIGURATION
//  - SIGNED_MULDIV_EN defined: MULT/DIV take magnitudes in IDLE and negate results in FIX.
//  - SIGNED_MULDIV_EN undefined: MULT/DIV behave exactly like MULTU/DIVU. The sign logic is
//    absent, and FIX is still spent so latency is identical.
// STRUCTURE
//  - muldiv_pkg: md_op_t enum, md_state_t enum {IDLE, CALC, FIX}, MD_WIDTH=32 constant.
//  - One sub-module: div_step. Combinational restoring step
//    (rem_in, quo_in, divisor -> rem_out, quo_out), instantiated once in CALC.
//  - Multiplier add and FSM/counter stay inline.
// TESTING
//  - MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE lo=0x00000001.
//    done high exactly 1 cycle; busy high 33 cycles.
//  - DIVU a=100 b=7 -> lo=14 hi=2. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x1234.
//  - MULT a=-3 b=5:
//    - with SIGNED_MULDIV_EN: hi=0xFFFFFFFF lo=0xFFFFFFF1.
//    - without it: hi=0x00000004 lo=0xFFFFFFF1.
//  - DIV a=-7 b=2 (macro on) -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//    DIV a=0x80000000 b=-1 -> lo=0x80000000 hi=0.
//  - MTHI a=0xA5A5A5A5 while idle -> hi=0xA5A5A5A5 next cycle, busy/done stay 0.
//    Same MTHI while busy -> hi unchanged. A second start mid-op is ignored.
//  - reset pulse at cycle 10 of a DIVU -> next cycle hi=lo=0, busy=0, done=0.
//    A new MULTU 6*7 afterwards -> lo=42 hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit that owns HI/LO.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MULTU = 3'd0,
    DIVU  = 3'd1,
    MULT  = 3'd2,
    DIV   = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == DIVU) || (op == DIV);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] trial_s;

  // The extra top bit of trial_s is the borrow; set means the divisor did not fit.
  assign trial_s = {rem_in, quo_in[WIDTH-1]} - {2'b00, divisor};
  assign rem_out = trial_s[WIDTH+1] ? {rem_in[WIDTH-1:0], quo_in[WIDTH-1]} : trial_s[WIDTH:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~trial_s[WIDTH+1]};

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative mul/div unit with HI/LO; IDLE -> CALC (WIDTH cycles) -> FIX -> IDLE.
// Optional macro SIGNED_MULDIV_EN enables signed MULT/DIV; without it they act as MULTU/DIVU.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   opa_in;
  logic [WIDTH-1:0]   opb_in;

`ifdef SIGNED_MULDIV_EN
  logic neg_a_q, neg_a_d;
  logic neg_b_q, neg_b_d;
  logic sgn_op;

  assign sgn_op   = (op == MULT) || (op == DIV);
  assign neg_a_d  = (state_q == IDLE) ? (sgn_op & a[WIDTH-1]) : neg_a_q;
  assign neg_b_d  = (state_q == IDLE) ? (sgn_op & b[WIDTH-1]) : neg_b_q;
  assign opa_in   = (sgn_op & a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
  assign opb_in   = (sgn_op & b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
  // Quotient and product take the XOR of the signs; the remainder follows the dividend.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? (~quo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_q;
  assign rem_fix  = neg_a_q ? (~rem_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q[WIDTH-1:0];

  // Sign flags, only touched while idle so a start mid-operation cannot disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end else begin
      neg_a_q <= neg_a_q;
      neg_b_q <= neg_b_q;
    end
  end
`else
  assign opa_in   = a;
  assign opb_in   = b;
  assign prod_fix = prod_q;
  assign quo_fix  = quo_q;
  assign rem_fix  = rem_q[WIDTH-1:0];
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (opb_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign mul_sum = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q})
                             : {1'b0, prod_q[2*WIDTH-1:WIDTH]};

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    a_d      = a_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MTHI: hi_d = a;
            MTLO: lo_d = a;
            MULTU, DIVU, MULT, DIV: begin
              state_d  = CALC;
              cnt_d    = {CW{1'b0}};
              is_div_d = op_is_div(op);
              b_zero_d = (b == {WIDTH{1'b0}});
              a_d      = a;
              opa_d    = opa_in;
              opb_d    = opb_in;
              prod_d   = {{WIDTH{1'b0}}, opb_in};
              rem_d    = {(WIDTH+1){1'b0}};
              quo_d    = opa_in;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (is_div_q) begin
          rem_d = step_rem;
          quo_d = step_quo;
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q && b_zero_q) begin
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      rem_q    <= {(WIDTH+1){1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
      a_q      <= a_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
